// File: rtl/board_led_status_ctrl.sv
// board_led_status_ctrl: NUM_LEDS channels (off/on/blink/event-stretch) driven from one shared prescaler.
// Optional BOARD_LED_EXIT_DISPLAY_EN: latch the SoC exit status and show it on led_o[0].
module board_led_status_ctrl #(
    parameter int NUM_LEDS       = 4,
    parameter int CNT_WIDTH      = 27,
    parameter int STRETCH_CYCLES = 2**20,
    parameter int CH_W           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk_gen,
    input  logic                rst_n,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [4:0]          cfg_div_i,
    output logic                cfg_err_o,
    input  logic [NUM_LEDS-1:0] evt_i,
    input  logic                exit_valid_i,
    input  logic [31:0]         exit_value_i,
    output logic [NUM_LEDS-1:0] led_o
);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CH_W:0] NL = NUM_LEDS[CH_W:0];
    localparam logic [4:0] MAXD = 5'(CNT_WIDTH - 1);
    typedef enum logic [2:0] {S_OFF, S_ON, S_BLINK, S_EVT_IDLE, S_EVT_ACTIVE} state_t;
    logic [CNT_WIDTH-1:0] presc;
    logic [31:0]          rev;
    logic [NUM_LEDS-1:0]  led_nxt, led_fin;
    logic                 acc, in_range, wr_ok;
    assign acc      = cfg_valid_i && cfg_ready_o;
    assign in_range = {1'b0, cfg_ch_i} < NL;
    assign wr_ok    = acc && in_range;
    // rev[d] selects the blink tap for effective divider d
    always_comb begin
        rev = '0;
        for (int i = 0; i < CNT_WIDTH; i++) rev[i] = presc[CNT_WIDTH-1-i];
    end
    always_ff @(posedge clk_gen or negedge rst_n)
        if (!rst_n) begin
            presc       <= '0;
            cfg_ready_o <= 1'b0;
            cfg_err_o   <= 1'b0;
            led_o       <= '0;
        end else begin
            presc       <= presc + 1'b1;
            cfg_ready_o <= 1'b1;
            cfg_err_o   <= acc && !in_range;
            led_o       <= led_fin;
        end
    for (genvar c = 0; c < NUM_LEDS; c++) begin : g_ch
        state_t        st;
        logic [4:0]    dv, eff;
        logic [SW-1:0] sc;
        logic          hit, ev_mode;
        assign hit     = wr_ok && cfg_ch_i == CH_W'(c);
        assign ev_mode = st == S_EVT_IDLE || st == S_EVT_ACTIVE;
        assign eff     = (dv > MAXD) ? MAXD : dv;
        assign led_nxt[c] = st == S_ON || (st == S_BLINK && rev[eff]) || st == S_EVT_ACTIVE;
        // a write on the same edge as an event wins and drops the event
        always_ff @(posedge clk_gen or negedge rst_n)
            if (!rst_n) begin
                st <= (c == 0) ? S_BLINK : S_OFF;
                dv <= '0;
                sc <= '0;
            end else if (hit) begin
                st <= state_t'({1'b0, cfg_mode_i});
                dv <= cfg_div_i;
                sc <= '0;
            end else if (ev_mode && evt_i[c]) begin
                st <= S_EVT_ACTIVE;
                sc <= SW'(STRETCH_CYCLES);
            end else if (sc != '0) begin
                st <= (sc == SW'(1)) ? S_EVT_IDLE : S_EVT_ACTIVE;
                sc <= sc - 1'b1;
            end
    end
`ifdef BOARD_LED_EXIT_DISPLAY_EN
    logic ex_set, ex_fail;
    always_ff @(posedge clk_gen or negedge rst_n)
        if (!rst_n) begin
            ex_set  <= 1'b0;
            ex_fail <= 1'b0;
        end else if (exit_valid_i && !ex_set) begin
            ex_set  <= 1'b1;
            ex_fail <= |exit_value_i;
        end
    always_comb begin
        led_fin = led_nxt;
        if (ex_set) led_fin[0] = ex_fail ? presc[CNT_WIDTH-4] : 1'b1;
    end
`else
    logic unused_exit;
    assign unused_exit = ^{exit_valid_i, exit_value_i};
    assign led_fin = led_nxt;
`endif
endmodule
